// File: rtl/bram_read_arbiter.sv
// ----------------------------------------------------------------------------
// bram_read_arbiter
//
// Shares the single read port of a one-cycle simple-dual-port block RAM
// between N_REQ read clients. Arbitration is round-robin and recomputed
// combinationally every cycle. Each RAM response is steered back to the
// client that issued the read. One write client passes straight through to
// the RAM write port and is never stalled.
//
// Optional feature (compile-time macro BRAM_ARB_RAW_STALL_EN):
//   defined   - a read whose winning address matches a same-cycle write is
//               held off for one cycle, so it returns the newly written data.
//   undefined - reads are granted regardless of writes and return the old
//               RAM contents on a same-address collision.
//
// Parameters
//   DATA_WIDTH  RAM word width
//   ADDR_WIDTH  RAM address width (2**ADDR_WIDTH words)
//   N_REQ       number of read clients, 2..16
//
// Ports
//   CLK, RST_N      clock (posedge) and synchronous active-low reset
//   RD_REQ          per-client read request, held until granted
//   RD_ADDR_IN      client i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   RD_GNT          one-hot combinational grant (request accepted this cycle)
//   RD_RSP_VALID    one-hot response strobe, one cycle after the grant
//   RD_RSP_DATA     shared response data (RAM read data)
//   WR_REQ          write request, always accepted out of reset
//   WR_ADDR_IN      write address
//   WR_DATA_IN      write data
//   BRAM_RE         RAM read enable
//   BRAM_RD_ADDR    RAM read address
//   BRAM_WE         RAM write enable
//   BRAM_WR_ADDR    RAM write address
//   BRAM_DI         RAM write data
//   BRAM_DO         RAM read data
//   BRAM_DO_VALID   RAM read-valid (read enable delayed one cycle)
//
// Handshake: RD_REQ[i] is the client's valid and RD_GNT[i] is the arbiter's
// ready. A read transfers in exactly the cycle where both are high; the
// client must keep RD_REQ[i] and its address stable until that cycle. The
// response has no back-pressure: RD_RSP_VALID[i] is a single-cycle strobe
// that the client must accept when it appears.
// ----------------------------------------------------------------------------
module bram_read_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int N_REQ      = 4
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [N_REQ-1:0]            RD_REQ,
    input  logic [N_REQ*ADDR_WIDTH-1:0] RD_ADDR_IN,
    output logic [N_REQ-1:0]            RD_GNT,
    output logic [N_REQ-1:0]            RD_RSP_VALID,
    output logic [DATA_WIDTH-1:0]       RD_RSP_DATA,
    input  logic                        WR_REQ,
    input  logic [ADDR_WIDTH-1:0]       WR_ADDR_IN,
    input  logic [DATA_WIDTH-1:0]       WR_DATA_IN,
    output logic                        BRAM_RE,
    output logic [ADDR_WIDTH-1:0]       BRAM_RD_ADDR,
    output logic                        BRAM_WE,
    output logic [ADDR_WIDTH-1:0]       BRAM_WR_ADDR,
    output logic [DATA_WIDTH-1:0]       BRAM_DI,
    input  logic [DATA_WIDTH-1:0]       BRAM_DO,
    input  logic                        BRAM_DO_VALID
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // rr_ptr: index of the most recently granted client; the search for the
    // next winner starts one past it.
    // rsp_tag: one-hot owner of the read that is in flight inside the RAM.
    logic [PW-1:0]         rr_ptr_q,  rr_ptr_d;
    logic [N_REQ-1:0]      rsp_tag_q, rsp_tag_d;

    logic [PW-1:0]         winner;
    logic                  any_req;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  stall;
    logic                  grant_en;
    logic [N_REQ-1:0]      gnt_vec;

    // ------------------------------------------------------------------
    // Round-robin search. Offsets are scanned from farthest to nearest so
    // that the nearest requesting client (smallest offset past rr_ptr) is
    // the last assignment and therefore wins.
    // ------------------------------------------------------------------
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int off = N_REQ; off >= 1; off--) begin
            int idx;
            idx = (int'(rr_ptr_q) + off) % N_REQ;
            if (RD_REQ[idx]) begin
                winner  = PW'(idx);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        win_addr = RD_ADDR_IN[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
    end

`ifdef BRAM_ARB_RAW_STALL_EN
    // Read-after-write collision: the RAM would return stale data, so the
    // whole grant is withheld this cycle. No other client is promoted into
    // the slot; the same winner is picked again next cycle because rr_ptr
    // holds, and by then the write has landed.
    always_comb begin
        stall = WR_REQ && (win_addr == WR_ADDR_IN);
    end
`else
    // Collisions are allowed through; the RAM returns its old contents.
    always_comb begin
        stall = 1'b0;
    end
`endif

    // ------------------------------------------------------------------
    // Grant, RAM read port and next-state
    // ------------------------------------------------------------------
    always_comb begin
        grant_en = RST_N && any_req && !stall;

        gnt_vec = '0;
        if (grant_en) begin
            gnt_vec[winner] = 1'b1;
        end

        rr_ptr_d  = grant_en ? winner : rr_ptr_q;
        // The tag follows the grant exactly, so it clears in idle or
        // stalled cycles and a late DO_VALID without an owner is dropped.
        rsp_tag_d = gnt_vec;
    end

    assign RD_GNT       = gnt_vec;
    assign BRAM_RE      = grant_en;
    assign BRAM_RD_ADDR = win_addr;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rr_ptr_q  <= PW'(N_REQ - 1);
            rsp_tag_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rsp_tag_q <= rsp_tag_d;
        end
    end

    // ------------------------------------------------------------------
    // Response routing. Gating with RST_N squashes the response of a read
    // granted in the cycle just before reset asserts.
    // ------------------------------------------------------------------
    assign RD_RSP_VALID = rsp_tag_q & {N_REQ{BRAM_DO_VALID & RST_N}};
    assign RD_RSP_DATA  = BRAM_DO;

    // ------------------------------------------------------------------
    // Write pass-through
    // ------------------------------------------------------------------
    assign BRAM_WE      = WR_REQ & RST_N;
    assign BRAM_WR_ADDR = WR_ADDR_IN;
    assign BRAM_DI      = WR_DATA_IN;

endmodule

// File: tb/tb_bram_read_arbiter.sv
module tb_bram_read_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int N  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic [N-1:0]  rd_req = '0;
  logic [N*AW-1:0] rd_addr_in = '0;
  logic [N-1:0]  rd_gnt;
  logic [N-1:0]  rd_rsp_valid;
  logic [DW-1:0] rd_rsp_data;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr_in = '0;
  logic [DW-1:0] wr_data_in = '0;
  logic          bram_re;
  logic [AW-1:0] bram_rd_addr;
  logic          bram_we;
  logic [AW-1:0] bram_wr_addr;
  logic [DW-1:0] bram_di;
  logic [DW-1:0] bram_do = '0;
  logic          bram_do_valid = 1'b0;

  bram_read_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REQ(N)) dut (
    .CLK(clk), .RST_N(rst_n),
    .RD_REQ(rd_req), .RD_ADDR_IN(rd_addr_in), .RD_GNT(rd_gnt),
    .RD_RSP_VALID(rd_rsp_valid), .RD_RSP_DATA(rd_rsp_data),
    .WR_REQ(wr_req), .WR_ADDR_IN(wr_addr_in), .WR_DATA_IN(wr_data_in),
    .BRAM_RE(bram_re), .BRAM_RD_ADDR(bram_rd_addr),
    .BRAM_WE(bram_we), .BRAM_WR_ADDR(bram_wr_addr), .BRAM_DI(bram_di),
    .BRAM_DO(bram_do), .BRAM_DO_VALID(bram_do_valid)
  );

  // ---------------- block RAM model ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bram_we) mem[bram_wr_addr] <= bram_di;
    bram_do       <= bram_re ? mem[bram_rd_addr] : '0;
    bram_do_valid <= bram_re;
  end

  // ---------------- reference model ----------------
  int            m_rr = N - 1;
  int            m_pend = -1;
  logic [DW-1:0] m_pend_data = '0;
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] exp_q [$];   // expected data of the read in flight

  logic [N-1:0]  exp_gnt, exp_rsp_valid;
  logic [DW-1:0] exp_rsp_data;
  logic [AW-1:0] exp_rd_addr;
  logic          exp_we;
  logic [AW-1:0] exp_wr_addr;
  logic [DW-1:0] exp_di;

  logic [N-1:0]  act_gnt, act_rsp_valid;
  logic [DW-1:0] act_rsp_data, act_di;
  logic [AW-1:0] act_rd_addr, act_wr_addr;
  logic          act_re, act_we;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic r, input logic [N-1:0] req, input logic [N*AW-1:0] addrs,
                       input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int  win;
    logic stalled;
    rst_n = r; rd_req = req; rd_addr_in = addrs;
    wr_req = w; wr_addr_in = wa; wr_data_in = wd;

    // Winner: first requesting client after the last granted one.
    win = -1;
    for (int k = N; k >= 1; k--) begin
      if (req[(m_rr + k) % N]) win = (m_rr + k) % N;
    end
    stalled = 1'b0;
`ifdef BRAM_ARB_RAW_STALL_EN
    if (win >= 0 && w && addrs[win*AW +: AW] == wa) stalled = 1'b1;
`endif
    exp_gnt = '0;
    if (r && win >= 0 && !stalled) exp_gnt[win] = 1'b1;
    exp_rd_addr   = (win >= 0) ? addrs[win*AW +: AW] : '0;
    exp_rsp_valid = '0;
    if (r && m_pend >= 0) exp_rsp_valid[m_pend] = 1'b1;
    exp_rsp_data  = m_pend_data;
    exp_we = r & w; exp_wr_addr = wa; exp_di = wd;

    @(negedge clk);
    act_gnt = rd_gnt; act_re = bram_re; act_rd_addr = bram_rd_addr;
    act_rsp_valid = rd_rsp_valid; act_rsp_data = rd_rsp_data;
    act_we = bram_we; act_wr_addr = bram_wr_addr; act_di = bram_di;

    // Advance the model across the coming clock edge.
    if (!r) begin
      m_rr = N - 1; m_pend = -1; exp_q.delete();
    end else if (exp_gnt != 0) begin
      m_rr = win; m_pend = win;
      exp_q.delete();
      exp_q.push_back(shadow[addrs[win*AW +: AW]]);  // old data: write lands after
      m_pend_data = exp_q[0];
    end else begin
      m_pend = -1; exp_q.delete();
    end
    if (r && w) shadow[wa] = wd;

    @(posedge clk); #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".gnt"}, 64'(act_gnt), 64'(exp_gnt));
    chk({tag, ".re"},  64'(act_re),  64'(exp_gnt != 0));
    if (exp_gnt != 0) chk({tag, ".rd_addr"}, 64'(act_rd_addr), 64'(exp_rd_addr));
    chk({tag, ".we"},  64'(act_we),  64'(exp_we));
    if (exp_we) begin
      chk({tag, ".wr_addr"}, 64'(act_wr_addr), 64'(exp_wr_addr));
      chk({tag, ".di"},      64'(act_di),      64'(exp_di));
    end
    chk({tag, ".rsp_valid"}, 64'(act_rsp_valid), 64'(exp_rsp_valid));
    if (exp_rsp_valid != 0) chk({tag, ".rsp_data"}, 64'(act_rsp_data), 64'(exp_rsp_data));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         r;
    logic [N-1:0] req;
    logic         w;
    logic [N-1:0] gnt;
    logic [N-1:0] rsp;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic r, logic [N-1:0] req, logic w, logic [N-1:0] gnt, logic [N-1:0] rsp);
    vec_t v;
    v.r = r; v.req = req; v.w = w; v.gnt = gnt; v.rsp = rsp;
    return v;
  endfunction

  logic [N*AW-1:0] fixed_addrs;
  logic [N*AW-1:0] a;
  logic [N-1:0]    cl_req;
  logic [AW-1:0]   cl_addr [N];

  initial begin
    for (int i = 0; i < N; i++) fixed_addrs[i*AW +: AW] = AW'(8 + i);

    // Reset with everything requesting
    repeat (3) tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 4'b0000));
    // Round-robin over 8 cycles, response one cycle after each grant
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0001, 4'b0000));
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0010, 4'b0001));
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0100, 4'b0010));
    tbl.push_back(mk(1, 4'b1111, 0, 4'b1000, 4'b0100));
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0001, 4'b1000));
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0010, 4'b0001));
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0100, 4'b0010));
    tbl.push_back(mk(1, 4'b1111, 0, 4'b1000, 4'b0100));
    tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 4'b1000));
    // Reset mid-operation: response squashed, client 0 first afterwards
    tbl.push_back(mk(1, 4'b0001, 0, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0001, 4'b0000));
    tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 4'b0001));
    // Sparse client 3, writes in the idle cycles
    repeat (3) begin
      tbl.push_back(mk(1, 4'b1000, 0, 4'b1000, 4'b0000));
      tbl.push_back(mk(1, 4'b0000, 1, 4'b0000, 4'b1000));
    end

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].req, fixed_addrs, tbl[i].w, AW'(100), 32'hDEAD_0000 + 32'(i));
      chk($sformatf("tbl%0d.gnt", i),       64'(act_gnt),       64'(tbl[i].gnt));
      chk($sformatf("tbl%0d.re", i),        64'(act_re),        64'(tbl[i].gnt != 0));
      chk($sformatf("tbl%0d.we", i),        64'(act_we),        64'(tbl[i].r & tbl[i].w));
      chk($sformatf("tbl%0d.rsp_valid", i), 64'(act_rsp_valid), 64'(tbl[i].rsp));
    end

    // Fill the addresses used below with known data
    for (int i = 0; i < 16; i++) begin
      cycle(1, '0, '0, 1, AW'(i), $urandom);
      check_model("init");
    end

    // Routing: write addr 3, then client 2 reads it
    cycle(1, '0, '0, 1, AW'(3), 32'hA5A5_0003);
    check_model("route_wr");
    a = '0; a[2*AW +: AW] = AW'(3);
    cycle(1, 4'b0100, a, 0, '0, '0);
    check_model("route_rd");
    chk("route.gnt", 64'(act_gnt), 64'(4'b0100));
    cycle(1, '0, '0, 0, '0, '0);
    check_model("route_rsp");
    chk("route.rsp_valid", 64'(act_rsp_valid), 64'(4'b0100));
    chk("route.rsp_data",  64'(act_rsp_data),  64'(32'hA5A5_0003));

    // Collision: addr 7 holds 0x11, same cycle write 0x22 and client 1 reads 7
    cycle(1, '0, '0, 1, AW'(7), 32'h11);
    check_model("col_pre");
    a = '0; a[1*AW +: AW] = AW'(7);
    cycle(1, 4'b0010, a, 1, AW'(7), 32'h22);
    check_model("col_hit");
`ifdef BRAM_ARB_RAW_STALL_EN
    chk("col.gnt_stalled", 64'(act_gnt), 64'(4'b0000));
    cycle(1, 4'b0010, a, 0, '0, '0);
    check_model("col_retry");
    chk("col.gnt_retry", 64'(act_gnt), 64'(4'b0010));
    cycle(1, '0, '0, 0, '0, '0);
    check_model("col_rsp");
    chk("col.rsp_valid", 64'(act_rsp_valid), 64'(4'b0010));
    chk("col.rsp_data",  64'(act_rsp_data),  64'(32'h22));
`else
    chk("col.gnt", 64'(act_gnt), 64'(4'b0010));
    cycle(1, '0, '0, 0, '0, '0);
    check_model("col_rsp");
    chk("col.rsp_valid", 64'(act_rsp_valid), 64'(4'b0010));
    chk("col.rsp_data",  64'(act_rsp_data),  64'(32'h11));
`endif

    // Randomized traffic against the model
    cl_req = '0;
    for (int i = 0; i < N; i++) cl_addr[i] = '0;
    for (int c = 0; c < 600; c++) begin
      logic r, w;
      r = ($urandom_range(0, 63) != 0);
      for (int i = 0; i < N; i++) begin
        if (!cl_req[i] && $urandom_range(0, 2) == 0) begin
          cl_req[i]  = 1'b1;
          cl_addr[i] = AW'($urandom_range(0, 15));
        end
        a[i*AW +: AW] = cl_addr[i];
      end
      w = ($urandom_range(0, 2) == 0);
      cycle(r, cl_req, a, w, AW'($urandom_range(0, 15)), $urandom);
      check_model("rand");
      cl_req = cl_req & ~exp_gnt;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
